// File: rtl/digit_unscramble.sv
// Digit-serial unscrambler: d = (7*in) mod 10, framed into N_DIGITS-digit words, 2-deep output buffer.
// Optional DIGIT_UNSCRAMBLE_SUM_EN adds out_sum, the per-word decoded digit sum mod 10 on the last digit.
module digit_unscramble #(
  parameter int N_DIGITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_last,
  output logic             digit_err,
  output logic             frame_err,
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
  output logic [3:0]       out_sum,
`endif
  output logic [CNT_W-1:0] word_count
);

  localparam int POS_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_DIGITS - 1);

  typedef enum logic {IDLE, IN_WORD} state_t;

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [1:0]       count;
  logic [3:0]       ent1_digit;
  logic             ent1_last;
  logic [3:0]       dec;
  logic             bad;
  logic             accept;
  logic             pop;
  logic             push;
  logic             push_last;

  function automatic logic [3:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 4'd0;
      4'd1:    decode = 4'd7;
      4'd2:    decode = 4'd4;
      4'd3:    decode = 4'd1;
      4'd4:    decode = 4'd8;
      4'd5:    decode = 4'd5;
      4'd6:    decode = 4'd2;
      4'd7:    decode = 4'd9;
      4'd8:    decode = 4'd6;
      4'd9:    decode = 4'd3;
      default: decode = 4'd0;
    endcase
  endfunction

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    dec       = decode(in_digit);
    bad       = (in_digit > 4'd9);
    push      = 1'b0;
    push_last = 1'b0;
    if (accept) begin
      if (in_first) begin
        push      = 1'b1;
        push_last = (N_DIGITS == 1);
      end else if (state == IN_WORD) begin
        push      = 1'b1;
        push_last = (pos == LAST_POS);
      end
    end
  end

`ifdef DIGIT_UNSCRAMBLE_SUM_EN
  logic [3:0] acc;
  logic [3:0] sum_base;
  logic [4:0] sum_raw;
  logic [3:0] sum_new;
  logic [3:0] push_sum;
  logic [3:0] ent1_sum;

  always_comb begin
    sum_base = in_first ? 4'd0 : acc;
    sum_raw  = 5'(sum_base) + 5'(dec);
    sum_new  = (sum_raw >= 5'd10) ? 4'(sum_raw - 5'd10) : sum_raw[3:0];
    push_sum = push_last ? sum_new : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (push) acc <= sum_new;
  end
`endif

  // Head of the buffer lives directly in the output registers; ent1 is the second slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      out_digit  <= '0;
      out_last   <= 1'b0;
      ent1_digit <= '0;
      ent1_last  <= 1'b0;
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
      out_sum    <= '0;
      ent1_sum   <= '0;
`endif
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            out_digit <= dec;
            out_last  <= push_last;
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
            out_sum   <= push_sum;
`endif
          end else begin
            ent1_digit <= dec;
            ent1_last  <= push_last;
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
            ent1_sum   <= push_sum;
`endif
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            out_digit <= ent1_digit;
            out_last  <= ent1_last;
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
            out_sum   <= ent1_sum;
`endif
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          out_digit <= dec;
          out_last  <= push_last;
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
          out_sum   <= push_sum;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pos        <= '0;
      word_count <= '0;
      digit_err  <= 1'b0;
      frame_err  <= 1'b0;
    end else if (accept) begin
      if (bad) digit_err <= 1'b1;
      if (in_first) begin
        if (state == IN_WORD) frame_err <= 1'b1;
        if (push_last) begin
          word_count <= word_count + CNT_W'(1);
          state      <= IDLE;
          pos        <= '0;
        end else begin
          state <= IN_WORD;
          pos   <= POS_W'(1);
        end
      end else if (state == IDLE) begin
        frame_err <= 1'b1;
      end else if (push_last) begin
        word_count <= word_count + CNT_W'(1);
        state      <= IDLE;
        pos        <= '0;
      end else begin
        pos <= pos + POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_digit_unscramble.sv
// Directed bench for digit_unscramble (N_DIGITS=4); outputs are logged per transfer and checked in order.
module tb_digit_unscramble;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_digit = '0;
  logic        in_first = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_digit;
  logic        out_last;
  logic        digit_err;
  logic        frame_err;
  logic [15:0] word_count;
  logic [3:0]  sum_seen;
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
  logic [3:0]  out_sum;
  assign sum_seen = out_sum;
`else
  assign sum_seen = 4'd0;
`endif

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [8:0] q[$];
  bit fork_done;

  digit_unscramble #(.N_DIGITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit), .out_last(out_last),
    .digit_err(digit_err), .frame_err(frame_err),
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
    .out_sum(out_sum),
`endif
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({sum_seen, out_last, out_digit});
    if (!rst && in_valid && in_ready) accepts++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    accepts = 0;
  endtask

  task automatic send(input logic [3:0] d, input logic f);
    bit ok = 0;
    in_valid = 1'b1; in_digit = d; in_first = f;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accept", ok, 1);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input logic [3:0] d, input logic l, input logic [3:0] s);
    logic [8:0] e;
    check({tag, "_avail"}, q.size() > 0, 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    check({tag, "_digit"}, e[3:0], d);
    check({tag, "_last"}, e[4], l);
`ifdef DIGIT_UNSCRAMBLE_SUM_EN
    check({tag, "_sum"}, e[8:5], s);
`endif
  endtask

  initial begin
    logic [3:0] exp2[12];
    logic [3:0] sums2[3];
    exp2  = '{4'd0, 4'd7, 4'd4, 4'd1, 4'd8, 4'd5, 4'd2, 4'd9, 4'd6, 4'd3, 4'd0, 4'd7};
    sums2 = '{4'd2, 4'd4, 4'd6};

    // reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_digit", out_digit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_word_count", word_count, 0);

    // basic word with one-cycle latency
    send(4'd3, 1'b1);
    check("lat_valid", out_valid, 1);
    check("lat_digit", out_digit, 1);
    send(4'd6, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0);
    drain();
    pop_check("w1a", 4'd1, 1'b0, 4'd0);
    pop_check("w1b", 4'd2, 1'b0, 4'd0);
    pop_check("w1c", 4'd3, 1'b0, 4'd0);
    pop_check("w1d", 4'd4, 1'b1, 4'd0);
    check("w1_count", word_count, 1);
    check("w1_derr", digit_err, 0);
    check("w1_ferr", frame_err, 0);
    check("w1_empty", q.size(), 0);

    // full decode table across words
    do_reset();
    for (int i = 0; i < 12; i++) send(4'(i % 10), (i % 4) == 0);
    drain();
    for (int i = 0; i < 12; i++)
      pop_check("map", exp2[i], (i % 4) == 3, ((i % 4) == 3) ? sums2[i / 4] : 4'd0);
    check("map_count", word_count, 3);

    // non-BCD digit, sticky flag
    do_reset();
    send(4'd3, 1'b1); send(4'd12, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0);
    drain();
    check("bcd_err", digit_err, 1);
    pop_check("bcd_a", 4'd1, 1'b0, 4'd0);
    pop_check("bcd_b", 4'd0, 1'b0, 4'd0);
    pop_check("bcd_c", 4'd3, 1'b0, 4'd0);
    pop_check("bcd_d", 4'd4, 1'b1, 4'd8);
    for (int i = 0; i < 4; i++) send(4'd0, i == 0);
    drain();
    check("bcd_sticky", digit_err, 1);
    check("bcd_count", word_count, 2);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    fork_done = 0;
    fork
      begin
        send(4'd3, 1'b1); send(4'd6, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0);
        fork_done = 1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("bp_accepts", accepts, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_valid", out_valid, 1);
    check("bp_hold_digit", out_digit, 1);
    check("bp_none_out", q.size(), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !fork_done; i++) @(posedge clk);
    check("bp_done", fork_done, 1);
    drain();
    pop_check("bp_a", 4'd1, 1'b0, 4'd0);
    pop_check("bp_b", 4'd2, 1'b0, 4'd0);
    pop_check("bp_c", 4'd3, 1'b0, 4'd0);
    pop_check("bp_d", 4'd4, 1'b1, 4'd0);
    check("bp_empty", q.size(), 0);
    check("bp_accepts_all", accepts, 4);

    // framing errors
    do_reset();
    send(4'd5, 1'b0);
    drain();
    check("fr_drop", q.size(), 0);
    check("fr_err", frame_err, 1);
    send(4'd3, 1'b1); send(4'd6, 1'b0);
    send(4'd3, 1'b1); send(4'd6, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0);
    drain();
    pop_check("fr_a", 4'd1, 1'b0, 4'd0);
    pop_check("fr_b", 4'd2, 1'b0, 4'd0);
    pop_check("fr_c", 4'd1, 1'b0, 4'd0);
    pop_check("fr_d", 4'd2, 1'b0, 4'd0);
    pop_check("fr_e", 4'd3, 1'b0, 4'd0);
    pop_check("fr_f", 4'd4, 1'b1, 4'd0);
    check("fr_count", word_count, 1);
    check("fr_sticky", frame_err, 1);

    // reset mid-word with full buffer
    out_ready = 1'b0;
    send(4'd3, 1'b1); send(4'd6, 1'b0);
    check("mr_full", in_ready, 0);
    do_reset();
    check("mr_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_count", word_count, 0);
    check("mr_ferr", frame_err, 0);
    out_ready = 1'b1;
    send(4'd3, 1'b1); send(4'd6, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0);
    drain();
    pop_check("mr_a", 4'd1, 1'b0, 4'd0);
    pop_check("mr_b", 4'd2, 1'b0, 4'd0);
    pop_check("mr_c", 4'd3, 1'b0, 4'd0);
    pop_check("mr_d", 4'd4, 1'b1, 4'd0);
    check("mr_words", word_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
